// File: rtl/alu.sv
// RV32IM execute unit: single-cycle RV32I and MUL* results, plus a fixed-latency
// radix-2 restoring divider for DIV/DIVU/REM/REMU.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        is_imm,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        ready,
    output logic [31:0] out,
    output logic        done
);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    logic        m_op_s;
    logic        div_op_s;
    logic        sub_s;
    logic [4:0]  shamt_s;
    logic [31:0] base_result_s;
    logic [31:0] mul_result_s;
    logic [31:0] comb_result_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic        div_signed_s;

    logic        busy_r;
    logic [4:0]  counter_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] divisor_r;
    logic [31:0] dividend_r;
    logic        neg_q_r;
    logic        neg_rem_r;
    logic        div_zero_r;
    logic        ovf_r;
    logic        is_rem_r;
    logic [31:0] div_result_r;
    logic        done_q_r;
    logic        div_mode_r;

    logic [32:0] rem_shift_s;
    logic        fits_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] div_final_s;

    assign m_op_s       = ~is_imm & (funct7 == 7'b0000001);
    assign div_op_s     = m_op_s & funct3[2];
    assign sub_s        = ~is_imm & funct7[5];
    assign shamt_s      = in2[4:0];
    assign div_signed_s = ~funct3[0];

    // Base RV32I result selection
    always_comb begin
        base_result_s = 32'd0;
        case (funct3)
            3'b000:  base_result_s = sub_s ? (in1 - in2) : (in1 + in2);
            3'b001:  base_result_s = in1 << shamt_s;
            3'b010:  base_result_s = {31'd0, ($signed(in1) < $signed(in2))};
            3'b011:  base_result_s = {31'd0, (in1 < in2)};
            3'b100:  base_result_s = in1 ^ in2;
            3'b101:  base_result_s = funct7[5] ? $unsigned($signed(in1) >>> shamt_s)
                                               : (in1 >> shamt_s);
            3'b110:  base_result_s = in1 | in2;
            3'b111:  base_result_s = in1 & in2;
            default: base_result_s = 32'd0;
        endcase
    end

    // One 64-bit multiplier; operand extension picks signed/unsigned high-half variants
    always_comb begin
        mul_a_s = {32'd0, in1};
        mul_b_s = {32'd0, in2};
        if ((funct3 == 3'b001) || (funct3 == 3'b010)) begin
            mul_a_s = {{32{in1[31]}}, in1};
        end else begin
            mul_a_s = {32'd0, in1};
        end
        if (funct3 == 3'b001) begin
            mul_b_s = {{32{in2[31]}}, in2};
        end else begin
            mul_b_s = {32'd0, in2};
        end
    end

    assign prod_s = mul_a_s * mul_b_s;

    // M-extension multiply result; divide codes are served by the divider path
    always_comb begin
        mul_result_s = 32'd0;
        case (funct3)
            3'b000:  mul_result_s = prod_s[31:0];
            3'b001:  mul_result_s = prod_s[63:32];
            3'b010:  mul_result_s = prod_s[63:32];
            3'b011:  mul_result_s = prod_s[63:32];
            default: mul_result_s = 32'd0;
        endcase
    end

    assign comb_result_s = m_op_s ? mul_result_s : base_result_s;

    // The partial remainder never exceeds the divisor, so the shifted value fits 33 bits
    // and the difference, when taken, fits back into 32.
    assign rem_shift_s = {rem_r, quo_r[31]};
    assign fits_s      = (rem_shift_s >= {1'b0, divisor_r});
    assign rem_next_s  = fits_s ? (rem_shift_s[31:0] - divisor_r) : rem_shift_s[31:0];
    assign quo_next_s  = {quo_r[30:0], fits_s};

    // Sign correction and special cases applied on the final divider step
    always_comb begin
        div_final_s = 32'd0;
        if (div_zero_r) begin
            div_final_s = is_rem_r ? dividend_r : 32'hFFFF_FFFF;
        end else if (ovf_r) begin
            div_final_s = is_rem_r ? 32'd0 : 32'h8000_0000;
        end else if (is_rem_r) begin
            div_final_s = neg_rem_r ? neg32(rem_next_s) : rem_next_s;
        end else begin
            div_final_s = neg_q_r ? neg32(quo_next_s) : quo_next_s;
        end
    end

    // Start/abort handling, one quotient bit per cycle, and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= 1'b0;
            counter_r    <= 5'd0;
            rem_r        <= 32'd0;
            quo_r        <= 32'd0;
            divisor_r    <= 32'd0;
            dividend_r   <= 32'd0;
            neg_q_r      <= 1'b0;
            neg_rem_r    <= 1'b0;
            div_zero_r   <= 1'b0;
            ovf_r        <= 1'b0;
            is_rem_r     <= 1'b0;
            div_result_r <= 32'd0;
            done_q_r     <= 1'b0;
            div_mode_r   <= 1'b0;
        end else if (ready) begin
            if (div_op_s) begin
                busy_r     <= 1'b1;
                counter_r  <= 5'd0;
                done_q_r   <= 1'b0;
                rem_r      <= 32'd0;
                quo_r      <= abs32(in1, div_signed_s);
                divisor_r  <= abs32(in2, div_signed_s);
                dividend_r <= in1;
                div_zero_r <= (in2 == 32'd0);
                ovf_r      <= div_signed_s & (in1 == 32'h8000_0000) & (in2 == 32'hFFFF_FFFF);
                neg_q_r    <= div_signed_s & (in1[31] ^ in2[31]);
                neg_rem_r  <= div_signed_s & in1[31];
                is_rem_r   <= funct3[1];
            end else begin
                busy_r     <= 1'b0;
                counter_r  <= 5'd0;
                done_q_r   <= 1'b1;
                div_mode_r <= 1'b0;
            end
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (counter_r == 5'd31) begin
                div_result_r <= div_final_s;
                done_q_r     <= 1'b1;
                div_mode_r   <= 1'b1;
                busy_r       <= 1'b0;
                counter_r    <= 5'd0;
            end else begin
                counter_r <= counter_r + 5'd1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign out  = div_mode_r ? div_result_r : comb_result_s;
    assign done = ready ? ~div_op_s : done_q_r;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors for base ops, multiplies,
// the iterative divider, abort-on-restart and mid-divide reset.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ready;
    logic [31:0] out;
    logic        done;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] F7_Z = 7'b0000000;
    localparam logic [6:0] F7_S = 7'b0100000;
    localparam logic [6:0] F7_M = 7'b0000001;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .is_imm (is_imm),
        .funct3 (funct3),
        .funct7 (funct7),
        .ready  (ready),
        .out    (out),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op with ready high mid-cycle; returns #1 after the falling edge.
    task automatic issue(input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        is_imm = imm;
        funct3 = f3;
        funct7 = f7;
        in1    = a;
        in2    = b;
        ready  = 1'b1;
        #1;
    endtask

    task automatic end_ready();
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic single(input string tag, input logic imm, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        issue(imm, f3, f7, a, b);
        check({tag, "_out"}, out, exp);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        end_ready();
        check({tag, "_hold"}, out, exp);
    endtask

    // Count edges after the start edge until done, bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic divide(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        issue(1'b0, f3, F7_M, a, b);
        check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
        end_ready();
        wait_done(n);
        check({tag, "_latency"}, n, 32'd32);
        check({tag, "_out"}, out, exp);
    endtask

    initial begin
        int n;
        int seen;
        rst    = 1'b0;
        ready  = 1'b0;
        is_imm = 1'b0;
        funct3 = 3'b000;
        funct7 = F7_Z;
        in1    = 32'd0;
        in2    = 32'd0;
        #12;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out", out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        single("add",    1'b0, 3'b000, F7_Z, 32'd5, 32'd7, 32'd12);
        single("sub",    1'b0, 3'b000, F7_S, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single("srai",   1'b1, 3'b101, F7_S, 32'h8000_0000, 32'd4, 32'hF800_0000);
        single("srl",    1'b0, 3'b101, F7_Z, 32'h8000_0000, 32'd4, 32'h0800_0000);
        single("slt",    1'b0, 3'b010, F7_Z, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("sltu",   1'b0, 3'b011, F7_Z, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("addi_m", 1'b1, 3'b000, F7_M, 32'd3, 32'h0000_002A, 32'd45);
        single("sll",    1'b0, 3'b001, F7_Z, 32'h0000_0003, 32'd33, 32'h0000_0006);
        single("xor",    1'b0, 3'b100, F7_Z, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
        single("or",     1'b0, 3'b110, F7_Z, 32'hF000_0001, 32'h0000_00F0, 32'hF000_00F1);
        single("and",    1'b0, 3'b111, F7_Z, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        single("mul",    1'b0, 3'b000, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        single("mulhu",  1'b0, 3'b011, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        single("mulh",   1'b0, 3'b001, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        single("mulhsu", 1'b0, 3'b010, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        divide("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        divide("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        divide("divu0",  3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        divide("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_done", {31'd0, done}, 32'd1);
            check("idle_out", out, 32'h8000_0000);
        end

        // Operands changed after the start edge must not reach the divide.
        issue(1'b0, 3'b111, F7_M, 32'h0000_1234, 32'd0);
        end_ready();
        in1 = 32'd0;
        in2 = 32'd5;
        wait_done(n);
        check("remu0_latency", n, 32'd32);
        check("remu0_out", out, 32'h0000_1234);

        // Restart in cycle 10 of a running divide.
        issue(1'b0, 3'b101, F7_M, 32'd100, 32'd7);
        end_ready();
        repeat (9) @(posedge clk);
        issue(1'b0, 3'b101, F7_M, 32'd50, 32'd5);
        check("abort_done_lo", {31'd0, done}, 32'd0);
        end_ready();
        wait_done(n);
        check("abort_latency", n, 32'd32);
        check("abort_out", out, 32'd10);

        // Reset in the middle of a divide.
        issue(1'b0, 3'b101, F7_M, 32'd100, 32'd7);
        end_ready();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("rst_no_result", seen, 32'd0);

        single("post_rst_add", 1'b0, 3'b000, F7_Z, 32'd1, 32'd2, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
